// File: rtl/audio_i2s_input.sv
// I2S capture: oversampled SCLK/LRCK/SDIN in, one stereo frame per LRCK period out.
// Define AUDIO_I2S_INPUT_FIFO_EN to buffer FIFO_DEPTH frames instead of one.
module audio_i2s_input #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_i2s_sclk,
  input  logic                    i_i2s_lrck,
  input  logic                    i_i2s_sdin,
  output logic [SAMPLE_WIDTH-1:0] o_left,
  output logic [SAMPLE_WIDTH-1:0] o_right,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_overrun,
  output logic                    o_locked
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [0:0] S_ALIGN = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [SAMPLE_WIDTH-1:0] TOP =
    {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic sclk_meta_q, sclk_sync_q, sclk_hist_q;
  logic lrck_meta_q, lrck_sync_q;
  logic sdin_meta_q, sdin_sync_q;
  logic rise;

  logic [0:0]              state_q, state_d;
  logic                    lr_prev_q, lr_prev_d;
  logic [CW-1:0]           bitcnt_q, bitcnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    left_ok_q, left_ok_d;
  logic                    locked_q, locked_d;
  logic [SAMPLE_WIDTH-1:0] word;
  logic                    frame_done;

  // Two-flop synchronisers; sclk gets a history flop for edge detection
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_hist_q <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      sdin_meta_q <= 1'b0;
      sdin_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= i_i2s_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_hist_q <= sclk_sync_q;
      lrck_meta_q <= i_i2s_lrck;
      lrck_sync_q <= lrck_meta_q;
      sdin_meta_q <= i_i2s_sdin;
      sdin_sync_q <= sdin_meta_q;
    end
  end

  assign rise = sclk_sync_q & ~sclk_hist_q;

  // Alignment and deserialiser; a frame needs a left word seen since lock
  always_comb begin
    state_d     = state_q;
    lr_prev_d   = lr_prev_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    locked_d    = locked_q;
    word        = shift_q;
    frame_done  = 1'b0;
    if (rise) begin
      lr_prev_d = lrck_sync_q;
      if (state_q == S_ALIGN) begin
        if (lrck_sync_q != lr_prev_q) begin
          state_d   = S_RUN;
          bitcnt_d  = '0;
          shift_d   = '0;
          left_ok_d = 1'b0;
          locked_d  = 1'b1;
        end
      end else begin
        if (bitcnt_q < CW'(SAMPLE_WIDTH)) begin
          if (sdin_sync_q) begin
            word = shift_q | (TOP >> bitcnt_q);
          end
          bitcnt_d = bitcnt_q + CW'(1);
        end
        shift_d = word;
        if (lrck_sync_q != lr_prev_q) begin
          bitcnt_d = '0;
          shift_d  = '0;
          if (!lr_prev_q) begin
            left_hold_d = word;
            left_ok_d   = 1'b1;
          end else begin
            frame_done = left_ok_q;
            left_ok_d  = 1'b0;
          end
        end
      end
    end
  end

  // Receiver state registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_ALIGN;
      lr_prev_q   <= 1'b0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lr_prev_q   <= lr_prev_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      locked_q    <= locked_d;
    end
  end

  assign o_locked = locked_q;

`ifdef AUDIO_I2S_INPUT_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [2*SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]               wptr_q, rptr_q;
  logic                      empty, full, pop, push;
  logic                      ovr_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && i_ready;
  assign push  = frame_done && (!full || pop);

  // Frame FIFO; a push into a full FIFO without a pop is dropped
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= frame_done && full && !pop;
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= {left_hold_q, word};
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  assign {o_left, o_right} = mem_q[rptr_q[AW-1:0]];
  assign o_valid   = !empty;
  assign o_overrun = ovr_q;
`else
  logic [SAMPLE_WIDTH-1:0] left_q, right_q;
  logic                    valid_q, ovr_q;

  // Single output register; a frame arriving while one is held is dropped
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (frame_done && (!valid_q || i_ready)) begin
        left_q  <= left_hold_q;
        right_q <= word;
        valid_q <= 1'b1;
      end else if (frame_done) begin
        ovr_q <= 1'b1;
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_left    = left_q;
  assign o_right   = right_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_audio_i2s_input.sv
// Directed bench for audio_i2s_input (default single-register build).
// Drives I2S streams at SCLK = clk/8 and checks captured frames.
module tb_audio_i2s_input;

  logic        clk;
  logic        rst;
  logic        sclk, lrck, sdin;
  logic [15:0] o_left, o_right;
  logic        o_valid, i_ready, o_overrun, o_locked;

  int errors = 0;
  int checks = 0;
  int vcyc = 0;
  int ovr = 0;
  logic pend = 1'b0;
  logic [15:0] cap_l[$];
  logic [15:0] cap_r[$];

  audio_i2s_input #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_i2s_sclk(sclk),
    .i_i2s_lrck(lrck),
    .i_i2s_sdin(sdin),
    .o_left    (o_left),
    .o_right   (o_right),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_overrun (o_overrun),
    .o_locked  (o_locked)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      cap_l.push_back(o_left);
      cap_r.push_back(o_right);
    end
    if (o_valid) vcyc++;
    if (o_overrun) ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic lr, input logic d);
    sclk = 1'b0;
    lrck = lr;
    sdin = d;
    #40;
    sclk = 1'b1;
    #40;
  endtask

  // Data lags LRCK by one slot: first slot carries the previous LSB
  task automatic word(input logic lr, input logic [23:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      slot(lr, pend);
      pend = v[n-1-k];
    end
  endtask

  initial begin
    logic [15:0] rv;
    rst = 1'b1;
    sclk = 1'b0;
    lrck = 1'b0;
    sdin = 1'b0;
    i_ready = 1'b1;
    settle(3);
    rst = 1'b0;
    settle(2);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_left", 32'(o_left), 32'd0);
    chk("rst_right", 32'(o_right), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    chk("rst_locked", 32'(o_locked), 32'd0);

    word(1'b0, 24'h00A5C3, 16);
    word(1'b1, 24'h001234, 16);
    word(1'b0, 24'h00A5C3, 16);
    word(1'b1, 24'h001234, 16);
    word(1'b0, 24'hABCDEF, 24);
    word(1'b1, 24'h123456, 24);
    word(1'b0, 24'h000FFF, 12);
    word(1'b1, 24'h000801, 12);
    word(1'b0, 24'h00AAAA, 16);
    word(1'b1, 24'h005555, 16);
    word(1'b0, 24'h000F0F, 16);
    settle(8);
    chk("locked", 32'(o_locked), 32'd1);
    chk("frame_count", 32'(cap_l.size()), 32'd4);
    if (cap_l.size() >= 4) begin
      chk("f16_left", 32'(cap_l[0]), 32'hA5C3);
      chk("f16_right", 32'(cap_r[0]), 32'h1234);
      chk("f24_left", 32'(cap_l[1]), 32'hABCD);
      chk("f24_right", 32'(cap_r[1]), 32'h1234);
      chk("f12_left", 32'(cap_l[2]), 32'hFFF0);
      chk("f12_right", 32'(cap_r[2]), 32'h8010);
      chk("alt_left", 32'(cap_l[3]), 32'hAAAA);
      chk("alt_right", 32'(cap_r[3]), 32'h5555);
    end
    chk("valid_cycles", 32'(vcyc), 32'd4);
    chk("no_overrun", 32'(ovr), 32'd0);

    i_ready = 1'b0;
    word(1'b1, 24'h000001, 16);
    word(1'b0, 24'h001111, 16);
    word(1'b1, 24'h002222, 16);
    word(1'b0, 24'h003333, 16);
    word(1'b1, 24'h004444, 16);
    word(1'b0, 24'h005A5A, 16);
    settle(8);
    chk("hold_valid", 32'(o_valid), 32'd1);
    chk("hold_left", 32'(o_left), 32'h0F0F);
    chk("hold_right", 32'(o_right), 32'h0001);
    chk("overrun_pulses", 32'(ovr), 32'd2);
    i_ready = 1'b1;
    settle(2);
    chk("drain_valid", 32'(o_valid), 32'd0);
    chk("drain_count", 32'(cap_l.size()), 32'd5);
    if (cap_l.size() >= 5) begin
      chk("drain_left", 32'(cap_l[4]), 32'h0F0F);
    end

    rv = 16'h9999;
    for (int k = 0; k < 7; k++) begin
      slot(1'b1, pend);
      pend = rv[15-k];
    end
    rst = 1'b1;
    settle(2);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_left", 32'(o_left), 32'd0);
    chk("mid_rst_right", 32'(o_right), 32'd0);
    chk("mid_rst_overrun", 32'(o_overrun), 32'd0);
    chk("mid_rst_locked", 32'(o_locked), 32'd0);
    rst = 1'b0;
    for (int k = 7; k < 16; k++) begin
      slot(1'b1, pend);
      pend = rv[15-k];
    end
    word(1'b0, 24'h00CAFE, 16);
    word(1'b1, 24'h00BEEF, 16);
    word(1'b0, 24'h000000, 16);
    settle(8);
    chk("relock", 32'(o_locked), 32'd1);
    chk("post_rst_count", 32'(cap_l.size()), 32'd6);
    if (cap_l.size() >= 6) begin
      chk("post_rst_left", 32'(cap_l[5]), 32'hCAFE);
      chk("post_rst_right", 32'(cap_r[5]), 32'hBEEF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
